inst_ctrl: RTL and testbench
============================

INST_CTRL -- requirements
Module: inst_ctrl

Interface
REQ-001 Parameter N, default 64, max vector length in elements.
REQ-002 Parameter BITS, default 8, byte/element width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000, idle-input cycles before command abort (used only with INST_CTRL_TIMEOUT_EN).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid / in_data  in  1 / BITS  byte from input_blk, valid for one cycle per byte.
REQ-007 vbuf_push / vbuf_clr  out  1 / 1  push in_data into vec number buffer; clear it.
REQ-008 sbuf_load  out  1  load in_data into scalar number buffer.
REQ-009 len_out  out  $clog2(N+1)  vector length for current command.
REQ-010 reg_wr / reg_sel  out  1 / 1  write data_bus_b into regbank; 0=A, 1=B.
REQ-011 alu_op / alu_start / alu_done  out / out / in  4 / 1 / 1  vec or reduce ALU op code, start pulse, completion pulse.
REQ-012 red_sel  out  1  1 selects reduce ALU onto out_bus, 0 selects vec out buffer.
REQ-013 out_start / out_done  out / in  1 / 1  start output_blk transfer; completion pulse.
REQ-014 busy / err  out  1 / 1  command in progress; sticky error.

Function
REQ-015 Opcode byte: in_data[7:4]=op, [3:0]=arg; 1 LOADV, 2 LOADS, 3 VOP, 4 RED, 5 READV; other ops illegal.
REQ-016 States: IDLE, GET_LEN, GET_ELEM, COMMIT, GET_SCAL, EXEC, WAIT_ALU, WRITE_RES, SEND, WAIT_OUT.
REQ-017 IDLE: on in_valid decode op; LOADV->GET_LEN with vbuf_clr pulse; LOADS->GET_SCAL; VOP/RED->EXEC with alu_op=arg latched; READV->SEND.
REQ-018 GET_LEN: byte L latched to len_out; L=0 or L>N sets err, ->IDLE; else ->GET_ELEM, element count=0.
REQ-019 GET_ELEM: each in_valid pulses vbuf_push same cycle, count+1; at count=L ->COMMIT.
REQ-020 COMMIT: one-cycle reg_wr with reg_sel=arg[0], ->IDLE.
REQ-021 GET_SCAL: next in_valid pulses sbuf_load, ->IDLE.
REQ-022 EXEC: one-cycle alu_start, ->WAIT_ALU; alu_done ->WRITE_RES (VOP) or SEND (RED, red_sel=1).
REQ-023 WRITE_RES: one-cycle reg_wr, reg_sel=1 (result to B), ->IDLE.
REQ-024 SEND: one-cycle out_start, ->WAIT_OUT; out_done ->IDLE, red_sel=0.
REQ-025 Illegal op: err set, byte discarded, stay IDLE.
REQ-026 in_valid outside IDLE/GET_LEN/GET_ELEM/GET_SCAL: byte dropped, err set.
REQ-027 alu_done/out_done outside their wait state ignored.
REQ-028 busy=1 in every state except IDLE; all strobes single-cycle, registered outputs, 1-cycle latency from triggering input.
REQ-029 err clears only on reset or on a LOADS/LOADV opcode with arg=4'hF (clear code, no payload, ->IDLE).

Reset
REQ-030 rst low: state IDLE, counters 0, len_out 0, alu_op 0, red_sel 0, all strobes 0, busy 0, err 0, immediately (asynchronous).
REQ-031 Reset mid-command abandons it; no residual strobe after release; first byte after release treated as opcode.

Configuration
REQ-032 INST_CTRL_TIMEOUT_EN defined: counter restarts on each in_valid in GET_LEN/GET_ELEM/GET_SCAL; reaching TIMEOUT_CYCLES sets err, ->IDLE, no reg_wr.
REQ-033 INST_CTRL_TIMEOUT_EN undefined: no counter, those states wait indefinitely.

Structure
REQ-034 Package vecacc_pkg: op enum (LOADV..READV), state enum, CLEAR_ARG=4'hF constant, length-width function.
REQ-035 One sub-module, cmd_watchdog (reload/expire counter), instantiated only under INST_CTRL_TIMEOUT_EN.

Verification
REQ-036 Bytes 0x10,0x03,0xAA,0xBB,0xCC -> vbuf_clr once, three vbuf_push, len_out=3, one reg_wr reg_sel=0, busy low after.
REQ-037 Bytes 0x10,0x00 and 0x10,N+1 -> err=1, no vbuf_push, no reg_wr, state IDLE.
REQ-038 0x32, alu_done 5 cycles later -> alu_op=2, one alu_start, one reg_wr reg_sel=1 cycle after done.
REQ-039 0x41, alu_done, out_done -> red_sel=1, out_start once, red_sel=0 after out_done; 0xE0 -> err=1; 0x1F -> err=0.
REQ-040 rst low during GET_ELEM after 2 of 4 elements -> all outputs reset; next 0x20,0x55 -> single sbuf_load.
REQ-041 INST_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: 0x10,0x04,one element, silence -> err=1 at cycle 16, no reg_wr.

Source files
------------

// File: rtl/vecacc_pkg.sv
// Shared opcode/state encodings and sizing helpers for the vector accelerator control path.
package vecacc_pkg;

  typedef enum logic [3:0] {
    OP_LOADV = 4'd1,
    OP_LOADS = 4'd2,
    OP_VOP   = 4'd3,
    OP_RED   = 4'd4,
    OP_READV = 4'd5
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_LEN,
    S_GET_ELEM,
    S_COMMIT,
    S_GET_SCAL,
    S_EXEC,
    S_WAIT_ALU,
    S_WRITE_RES,
    S_SEND,
    S_WAIT_OUT
  } state_e;

  // LOADV/LOADS with this argument clear the sticky error instead of loading.
  localparam logic [3:0] CLEAR_ARG = 4'hF;

  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/inst_ctrl_if.sv
// Control bundle between inst_ctrl (master) and the input/buffer/ALU/output datapath (slave).
interface inst_ctrl_if #(
  parameter int N    = 64,
  parameter int BITS = 8
);
  localparam int LW = vecacc_pkg::len_w(N);

  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            vbuf_push;
  logic            vbuf_clr;
  logic            sbuf_load;
  logic [LW-1:0]   len_out;
  logic            reg_wr;
  logic            reg_sel;
  logic [3:0]      alu_op;
  logic            alu_start;
  logic            alu_done;
  logic            red_sel;
  logic            out_start;
  logic            out_done;
  logic            busy;
  logic            err;

  modport master (
    input  in_valid, in_data, alu_done, out_done,
    output vbuf_push, vbuf_clr, sbuf_load, len_out, reg_wr, reg_sel,
           alu_op, alu_start, red_sel, out_start, busy, err
  );

  modport slave (
    output in_valid, in_data, alu_done, out_done,
    input  vbuf_push, vbuf_clr, sbuf_load, len_out, reg_wr, reg_sel,
           alu_op, alu_start, red_sel, out_start, busy, err
  );

endinterface

// File: rtl/inst_ctrl_cmd_watchdog.sv
// Idle-input watchdog: restarts on reload or when inactive, expires after CYCLES idle cycles.
// Combinational expire, one cycle per count; no backpressure.
module cmd_watchdog #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic reload,
  output logic expire
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign expire = active && !reload && (cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!active || reload) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/inst_ctrl.sv
// Byte-stream command decoder sequencing vector load, scalar load, ALU and readout; strobes registered, 1 cycle after trigger.
// No backpressure: bytes arriving when not expected are dropped and flag err. Option: INST_CTRL_TIMEOUT_EN.
module inst_ctrl
  import vecacc_pkg::*;
#(
  parameter int N              = 64,
  parameter int BITS           = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  inst_ctrl_if.master bus
);

  localparam int LW = len_w(N);

  state_e        state, state_d;
  logic [LW-1:0] cnt, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic          sel_arg_q, sel_arg_d;
  logic          is_red_q, is_red_d;
  logic          red_sel_q, red_sel_d;
  logic          err_q, err_d;
  logic          reg_sel_q, reg_sel_d;
  logic          vbuf_clr_d;
  logic          vbuf_clr_q, reg_wr_q, alu_start_q, out_start_q, busy_q;

  logic [3:0]    op, arg;
  logic [31:0]   len_byte;
  logic          accepting, waiting, wd_expire;

  assign op        = bus.in_data[7:4];
  assign arg       = bus.in_data[3:0];
  assign len_byte  = 32'(bus.in_data);
  assign waiting   = (state == S_GET_LEN) || (state == S_GET_ELEM) || (state == S_GET_SCAL);
  assign accepting = waiting || (state == S_IDLE);

`ifdef INST_CTRL_TIMEOUT_EN
  cmd_watchdog #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_cmd_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (waiting),
    .reload (bus.in_valid),
    .expire (wd_expire)
  );
`else
  // Watchdog not built: payload states wait indefinitely.
  assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    len_d      = len_q;
    alu_op_d   = alu_op_q;
    sel_arg_d  = sel_arg_q;
    is_red_d   = is_red_q;
    red_sel_d  = red_sel_q;
    err_d      = err_q;
    reg_sel_d  = reg_sel_q;
    vbuf_clr_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          case (op)
            OP_LOADV, OP_LOADS: begin
              if (arg == CLEAR_ARG) begin
                err_d = 1'b0;
              end else if (op == OP_LOADV) begin
                state_d    = S_GET_LEN;
                vbuf_clr_d = 1'b1;
                sel_arg_d  = arg[0];
              end else begin
                state_d = S_GET_SCAL;
              end
            end
            OP_VOP, OP_RED: begin
              state_d  = S_EXEC;
              alu_op_d = arg;
              is_red_d = (op == OP_RED);
            end
            OP_READV: begin
              state_d   = S_SEND;
              red_sel_d = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_GET_LEN: begin
        if (bus.in_valid) begin
          len_d = LW'(bus.in_data);
          if ((len_byte == 32'd0) || (len_byte > 32'(N))) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_GET_ELEM;
          end
        end
      end
      S_GET_ELEM: begin
        if (bus.in_valid) begin
          cnt_d = cnt + LW'(1);
          if (cnt_d == len_q) begin
            state_d   = S_COMMIT;
            reg_sel_d = sel_arg_q;
          end
        end
      end
      S_COMMIT:   state_d = S_IDLE;
      S_GET_SCAL: if (bus.in_valid) state_d = S_IDLE;
      S_EXEC:     state_d = S_WAIT_ALU;
      S_WAIT_ALU: begin
        if (bus.alu_done) begin
          if (is_red_q) begin
            state_d   = S_SEND;
            red_sel_d = 1'b1;
          end else begin
            state_d   = S_WRITE_RES;
            reg_sel_d = 1'b1;
          end
        end
      end
      S_WRITE_RES: state_d = S_IDLE;
      S_SEND:      state_d = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (bus.out_done) begin
          state_d   = S_IDLE;
          red_sel_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.in_valid && !accepting) err_d = 1'b1;

    if (wd_expire) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      len_q       <= '0;
      alu_op_q    <= '0;
      sel_arg_q   <= 1'b0;
      is_red_q    <= 1'b0;
      red_sel_q   <= 1'b0;
      err_q       <= 1'b0;
      reg_sel_q   <= 1'b0;
      vbuf_clr_q  <= 1'b0;
      reg_wr_q    <= 1'b0;
      alu_start_q <= 1'b0;
      out_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      len_q       <= len_d;
      alu_op_q    <= alu_op_d;
      sel_arg_q   <= sel_arg_d;
      is_red_q    <= is_red_d;
      red_sel_q   <= red_sel_d;
      err_q       <= err_d;
      reg_sel_q   <= reg_sel_d;
      vbuf_clr_q  <= vbuf_clr_d;
      reg_wr_q    <= (state_d == S_COMMIT) || (state_d == S_WRITE_RES);
      alu_start_q <= (state_d == S_EXEC);
      out_start_q <= (state_d == S_SEND);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Buffer writes must coincide with the byte itself, so these two are gated straight from in_valid.
  assign bus.vbuf_push = (state == S_GET_ELEM) && bus.in_valid;
  assign bus.sbuf_load = (state == S_GET_SCAL) && bus.in_valid;
  assign bus.vbuf_clr  = vbuf_clr_q;
  assign bus.len_out   = len_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_sel   = reg_sel_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_start = alu_start_q;
  assign bus.red_sel   = red_sel_q;
  assign bus.out_start = out_start_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_inst_ctrl.sv
// Directed and randomized command streams against a transaction-level model of the controller.
module tb_inst_ctrl;
  import vecacc_pkg::*;

  localparam int N    = 64;
  localparam int BITS = 8;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_ctrl_if #(.N(N), .BITS(BITS)) bus ();

  inst_ctrl #(
    .N              (N),
    .BITS           (BITS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  int   n_clr = 0, n_push = 0, n_sload = 0, n_regwr = 0, n_astart = 0, n_ostart = 0;
  int   regwr_cyc = 0, done_cyc = 0;
  logic last_sel = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.vbuf_clr)  n_clr    <= n_clr + 1;
    if (bus.vbuf_push) n_push   <= n_push + 1;
    if (bus.sbuf_load) n_sload  <= n_sload + 1;
    if (bus.alu_start) n_astart <= n_astart + 1;
    if (bus.out_start) n_ostart <= n_ostart + 1;
    if (bus.alu_done)  done_cyc <= cyc;
    if (bus.reg_wr) begin
      n_regwr   <= n_regwr + 1;
      regwr_cyc <= cyc;
      last_sel  <= bus.reg_sel;
    end
  end

  int checks = 0;
  int errors = 0;
  int b_clr, b_push, b_sload, b_regwr, b_astart, b_ostart;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic pulse_alu();
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
  endtask

  task automatic pulse_out();
    bus.out_done = 1'b1;
    tick();
    bus.out_done = 1'b0;
  endtask

  task automatic snap();
    b_clr = n_clr; b_push = n_push; b_sload = n_sload;
    b_regwr = n_regwr; b_astart = n_astart; b_ostart = n_ostart;
  endtask

  task automatic chk_cnt(input string tag, input int clr, input int push, input int sload,
                         input int regwr, input int astart, input int ostart);
    chk({tag, ".clr"},    n_clr - b_clr,       clr);
    chk({tag, ".push"},   n_push - b_push,     push);
    chk({tag, ".sload"},  n_sload - b_sload,   sload);
    chk({tag, ".regwr"},  n_regwr - b_regwr,   regwr);
    chk({tag, ".astart"}, n_astart - b_astart, astart);
    chk({tag, ".ostart"}, n_ostart - b_ostart, ostart);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && bus.busy !== 1'b0; i++) tick();
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [5:0] strobes();
    return {bus.vbuf_push, bus.vbuf_clr, bus.sbuf_load, bus.reg_wr, bus.alu_start, bus.out_start};
  endfunction

  initial begin
    int          kind, len, r;
    logic [3:0]  arg, o;
    logic        stray;
    logic        m_err;
    int          m_len, m_alu;
    int          e_clr, e_push, e_sload, e_regwr, e_astart, e_ostart;
    logic        e_sel;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.alu_done = 1'b0;
    bus.out_done = 1'b0;

    // Reset asserted between clock edges: outputs must clear without a clock.
    #2 rst = 1'b0;
    #1;
    chk("rst.busy",    32'(bus.busy),    0);
    chk("rst.err",     32'(bus.err),     0);
    chk("rst.len",     32'(bus.len_out), 0);
    chk("rst.aluop",   32'(bus.alu_op),  0);
    chk("rst.redsel",  32'(bus.red_sel), 0);
    chk("rst.strobes", 32'(strobes()),   0);
    tick(2);
    rst = 1'b1;
    tick();

    // Vector load of three elements into A.
    snap();
    send(8'h10);
    chk("lv.clr_lat", 32'(bus.vbuf_clr), 1);
    chk("lv.busy",    32'(bus.busy),     1);
    send(8'h03);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    chk("lv.regwr_lat", 32'(bus.reg_wr),  1);
    chk("lv.regsel",    32'(bus.reg_sel), 0);
    tick();
    chk("lv.busy_after", 32'(bus.busy), 0);
    chk_cnt("lv", 1, 3, 0, 1, 0, 0);
    chk("lv.len", 32'(bus.len_out), 3);
    chk("lv.err", 32'(bus.err),     0);

    // Zero and oversize lengths.
    snap();
    send(8'h10);
    send(8'h00);
    tick();
    chk("len0.err", 32'(bus.err), 1);
    wait_idle("len0");
    chk_cnt("len0", 1, 0, 0, 0, 0, 0);
    send(8'h1F);
    tick();
    chk("clr1.err", 32'(bus.err), 0);
    snap();
    send(8'h10);
    send(8'(N + 1));
    tick();
    chk("lenbig.err", 32'(bus.err),     1);
    chk("lenbig.len", 32'(bus.len_out), N + 1);
    wait_idle("lenbig");
    chk_cnt("lenbig", 1, 0, 0, 0, 0, 0);
    send(8'h2F);
    tick();
    chk("clr2.err", 32'(bus.err), 0);

    // Completion pulses while idle are ignored.
    snap();
    pulse_alu();
    pulse_out();
    tick();
    chk_cnt("stray_done", 0, 0, 0, 0, 0, 0);
    chk("stray_done.busy", 32'(bus.busy), 0);
    chk("stray_done.err",  32'(bus.err),  0);

    // Vector op, ALU done five cycles after the opcode.
    snap();
    send(8'h32);
    chk("vop.astart_lat", 32'(bus.alu_start), 1);
    chk("vop.aluop",      32'(bus.alu_op),    2);
    tick(4);
    pulse_alu();
    chk("vop.regwr_lat", 32'(bus.reg_wr),  1);
    chk("vop.regsel",    32'(bus.reg_sel), 1);
    wait_idle("vop");
    chk("vop.done_to_wr", regwr_cyc - done_cyc, 1);
    chk_cnt("vop", 0, 0, 0, 1, 1, 0);

    // Reduce then readout through out_bus.
    snap();
    send(8'h41);
    tick(2);
    pulse_alu();
    chk("red.redsel",   32'(bus.red_sel),   1);
    chk("red.ostart",   32'(bus.out_start), 1);
    tick(2);
    chk("red.redsel_hold", 32'(bus.red_sel), 1);
    pulse_out();
    chk("red.redsel_off", 32'(bus.red_sel), 0);
    wait_idle("red");
    chk_cnt("red", 0, 0, 0, 0, 1, 1);
    chk("red.aluop", 32'(bus.alu_op), 1);
    send(8'hE0);
    tick();
    chk("illegal.err", 32'(bus.err), 1);
    send(8'h1F);
    tick();
    chk("clr3.err", 32'(bus.err), 0);

    // Reset in the middle of a vector load.
    snap();
    send(8'h10);
    send(8'h04);
    send(8'h55);
    send(8'h66);
    chk("mid.push", n_push - b_push, 2);
    chk("mid.busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("mid.rst_busy",    32'(bus.busy),    0);
    chk("mid.rst_len",     32'(bus.len_out), 0);
    chk("mid.rst_aluop",   32'(bus.alu_op),  0);
    chk("mid.rst_strobes", 32'(strobes()),   0);
    tick(2);
    rst = 1'b1;
    tick();
    snap();
    send(8'h20);
    send(8'h55);
    tick();
    chk_cnt("post_rst", 0, 0, 1, 0, 0, 0);
    chk("post_rst.err",  32'(bus.err),  0);
    chk("post_rst.busy", 32'(bus.busy), 0);

`ifdef INST_CTRL_TIMEOUT_EN
    // Silence after a partial load: err exactly TO cycles after the last byte.
    snap();
    send(8'h10);
    send(8'h04);
    send(8'h77);
    tick(TO - 1);
    chk("to.err_early", 32'(bus.err), 0);
    tick();
    chk("to.err", 32'(bus.err), 1);
    wait_idle("to");
    chk_cnt("to", 1, 1, 0, 0, 0, 0);
    send(8'h1F);
    tick();
`endif

    // Random command stream against a command-level model.
    m_err = bus.err;
    m_len = int'(bus.len_out);
    m_alu = int'(bus.alu_op);
    for (int it = 0; it < 40; it++) begin
      kind  = int'($urandom_range(0, 7));
      arg   = 4'($urandom_range(0, 14));
      stray = ($urandom_range(0, 3) == 0);
      e_clr = 0; e_push = 0; e_sload = 0; e_regwr = 0; e_astart = 0; e_ostart = 0;
      e_sel = 1'b0;
      snap();
      case (kind)
        0: begin
          r = int'($urandom_range(0, 9));
          len = (r == 0) ? 0 : (r == 1) ? N + 1 : int'($urandom_range(1, 8));
          send({4'h1, arg});
          send(8'(len));
          e_clr = 1;
          m_len = len;
          if (len == 0 || len > N) begin
            m_err = 1'b1;
          end else begin
            for (int k = 0; k < len; k++) send(8'($urandom));
            e_push  = len;
            e_regwr = 1;
            e_sel   = arg[0];
          end
        end
        1: begin
          send({4'h2, arg});
          send(8'($urandom));
          e_sload = 1;
        end
        2: begin
          o = 4'($urandom_range(0, 15));
          send({4'h3, o});
          tick();
          if (stray) begin
            send(8'($urandom));
            m_err = 1'b1;
          end
          tick(int'($urandom_range(0, 4)));
          pulse_alu();
          m_alu    = int'(o);
          e_astart = 1;
          e_regwr  = 1;
          e_sel    = 1'b1;
        end
        3: begin
          o = 4'($urandom_range(0, 15));
          send({4'h4, o});
          tick(int'($urandom_range(1, 3)));
          pulse_alu();
          tick();
          if (stray) begin
            send(8'($urandom));
            m_err = 1'b1;
          end
          tick(int'($urandom_range(0, 2)));
          pulse_out();
          m_alu    = int'(o);
          e_astart = 1;
          e_ostart = 1;
        end
        4: begin
          send({4'h5, 4'($urandom)});
          tick(int'($urandom_range(1, 3)));
          pulse_out();
          e_ostart = 1;
        end
        5: begin
          o = 4'($urandom_range(5, 15));
          if (o == 4'd5) o = 4'd0;
          send({o, arg});
          m_err = 1'b1;
        end
        6: begin
          send({4'($urandom_range(1, 2)), 4'hF});
          m_err = 1'b0;
        end
        default: begin
          pulse_alu();
          pulse_out();
        end
      endcase
      wait_idle("rnd");
      tick();
      chk_cnt("rnd", e_clr, e_push, e_sload, e_regwr, e_astart, e_ostart);
      chk("rnd.err",    32'(bus.err),     32'(m_err));
      chk("rnd.len",    32'(bus.len_out), m_len);
      chk("rnd.aluop",  32'(bus.alu_op),  m_alu);
      chk("rnd.redsel", 32'(bus.red_sel), 0);
      if (e_regwr != 0) chk("rnd.regsel", 32'(last_sel), 32'(e_sel));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
